jtag_tap_driver: RTL
====================

# jtag_tap_driver

Command-driven JTAG master that generates TCK/TMS/TDI and samples TDO to walk a 16-state TAP controller through reset, IR scans, DR scans and idle cycles. It sits between a simple valid/ready command source (test sequencer or host bridge) and the JTAG pins of the TAP block. It keeps a mirror of the target TAP state using the standard 4-bit state encoding (Test_Logic_Reset=0000 … Update_IR=1111).

## Interface
- DATA_W, 32, max bits shifted per scan command; also the width of cmd_data and rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > DATA_W.
- clk  in  1  system clock; TCK is derived from it.
- TRST  in  1  reset, synchronous, active-high; resets this block only.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle run.
- cmd_len  in  LEN_W  bit count for scans, TCK count for idle run.
- cmd_data  in  DATA_W  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-clk pulse when a command completes.
- rsp_data  out  DATA_W  captured TDO bits, LSB = first sampled bit; held until the next completion.
- busy  out  1  command in progress (equals !cmd_ready).
- TCK  out  1  JTAG clock; period = 2 clk.
- TMS  out  1  JTAG mode select.
- TDI  out  1  JTAG data to target.
- TDO  in  1  JTAG data from target.
- tap_state  out  4  mirrored TAP state (only with JTAG_DRV_STATE_OBS_EN).

## Operation
- Every JTAG bit occupies two clk cycles: phase L (TCK=0), then phase H (TCK=1). TMS/TDI change only on the clk edge that enters phase L.
- Internal FSM: IDLE → PRE → SHIFT → POST → DONE → IDLE.
  - IDLE: cmd_ready=1, TCK=0. On accept, latch op, len and data.
  - PRE (navigation TMS bits): op 00 = 1,1,1,1,1,0 (ends in Run_Test_Idle). Op 10 = 1,0,0 (RTI→Select_DR→Capture_DR→Shift_DR). Op 01 = 1,1,0,0. Op 11 has no PRE bits.
  - If tap_state is Test_Logic_Reset when a 01/10/11 op starts, one extra TMS=0 bit is prepended.
  - SHIFT, op 01/10: len bits, TDI = data[i]. TMS=0 except the last bit, where TMS=1 (moves to Exit1). TDO is sampled into bit i.
  - SHIFT, op 11: len bits with TMS=0, TDI=0.
  - POST, op 01/10: TMS = 1, 0 (Update → Run_Test_Idle). Other ops have no POST bits.
  - DONE: one clk with rsp_valid=1; the next cycle is IDLE.
- cmd_len: values above DATA_W are clamped to DATA_W.
  - len=0 for op 01/10: PRE and POST are skipped, no TCK pulses, rsp_data=0, rsp_valid still pulses.
  - len=0 for op 11: completes with no TCK pulses.
- rsp_data bits at or above len read 0. For op 00/11, rsp_data=0.
- Mirror tap_state advances per the IEEE 1149.1 transition table on every TCK rising edge, using the TMS value being driven.
- cmd_valid while busy is ignored (not queued).

## Timing
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, tap_state=0000, FSM=IDLE.
- TRST mid-command: abort on the same edge, all outputs take their reset values, and no rsp_valid is produced.
  - The target may then be in any state. The first command after TRST must be op 00.
- Accept edge N: the first phase L begins at edge N+1.
- Total bits B: op 00 = 6; op 10 = 3+len+2; op 01 = 4+len+2; op 11 = len. Add 1 if starting from Test_Logic_Reset.
- rsp_valid is high in the cycle starting at edge N+1+2B; cmd_ready returns at edge N+2+2B.
- TDO is registered on the clk edge where TCK goes 0→1, i.e. at the end of phase L. tap_state updates on the same edge.
- Back-to-back: a command accepted in the first cycle with cmd_ready=1 starts without gap.

## Configuration
- JTAG_DRV_STATE_OBS_EN defined: the tap_state output port exists and is driven as above.
- Undefined: the tap_state port is absent. State tracking remains internal, since it is needed for the Test_Logic_Reset prepend. All other behaviour is identical.

## Test plan
- After TRST, op 00 accepted at edge N: TMS sequence 1,1,1,1,1,0 over 12 clk; rsp_valid at edge N+13; tap_state=0001 at completion.
- From RTI, op 10, len=8, data=0xA5, target DR preloaded 0x3C: TDI bit stream 1,0,1,0,0,1,0,1; rsp_data=0x0000003C; 13 TCK pulses; tap_state=0001 at end.
- From RTI, op 01, len=4, data=0x5, capture value 0b0001: TMS = 1,1,0,0,0,0,0,1,1,0; rsp_data=0x1; target IR=0x5.
- Op 10 with len=40: clamped to 32 bits, 37 TCK pulses; op 10 with len=0: no TCK pulses, rsp_valid within 2 clk of accept, rsp_data=0.
- TRST asserted during SHIFT bit 3 of a DR scan: next edge TCK=0, TMS=1, cmd_ready=1, and no rsp_valid; a following op 00 then op 10 scan behave normally.
- Op 11, len=5 issued directly after TRST (tap_state=0000): one prepended TMS=0 bit plus 5 TMS=0 bits, 6 TCK pulses total.

Source files
------------

// File: rtl/jtag_tap_driver.sv
// Command-driven JTAG master: walks a 1149.1 TAP through reset, IR/DR scans and idle runs.
// Define JTAG_DRV_STATE_OBS_EN to expose the mirrored TAP state on the tap_state port.
module jtag_tap_driver #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
`ifdef JTAG_DRV_STATE_OBS_EN
  ,
  output logic [3:0]        tap_state
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PRE, S_SHIFT, S_POST, S_DONE} drv_state_t;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  localparam logic [3:0] ST_TLR   = 4'h0, ST_RTI   = 4'h1, ST_SELDR = 4'h2, ST_CAPDR = 4'h3;
  localparam logic [3:0] ST_SHDR  = 4'h4, ST_EX1DR = 4'h5, ST_PSDR  = 4'h6, ST_EX2DR = 4'h7;
  localparam logic [3:0] ST_UPDR  = 4'h8, ST_SELIR = 4'h9, ST_CAPIR = 4'hA, ST_SHIR  = 4'hB;
  localparam logic [3:0] ST_EX1IR = 4'hC, ST_PSIR  = 4'hD, ST_EX2IR = 4'hE, ST_UPIR  = 4'hF;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    case (s)
      ST_TLR:   n = tms ? ST_TLR   : ST_RTI;
      ST_RTI:   n = tms ? ST_SELDR : ST_RTI;
      ST_SELDR: n = tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: n = tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  n = tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: n = tms ? ST_UPDR  : ST_PSDR;
      ST_PSDR:  n = tms ? ST_EX2DR : ST_PSDR;
      ST_EX2DR: n = tms ? ST_UPDR  : ST_SHDR;
      ST_UPDR:  n = tms ? ST_SELDR : ST_RTI;
      ST_SELIR: n = tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: n = tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  n = tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: n = tms ? ST_UPIR  : ST_PSIR;
      ST_PSIR:  n = tms ? ST_EX2IR : ST_PSIR;
      ST_EX2IR: n = tms ? ST_UPIR  : ST_SHIR;
      default:  n = tms ? ST_SELDR : ST_RTI;
    endcase
    return n;
  endfunction

  drv_state_t         state_q, state_d;
  logic               phase_q, phase_d;
  logic [1:0]         op_q, op_d;
  logic [6:0]         pre_pat_q, pre_pat_d;
  logic [2:0]         pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]   sh_left_q, sh_left_d;
  logic [1:0]         post_left_q, post_left_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0]  mask_q, mask_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [3:0]         tap_q, tap_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               is_scan;
  logic               new_scan;
  logic [LEN_W-1:0]   len_cl;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    op_d        = op_q;
    pre_pat_d   = pre_pat_q;
    pre_cnt_d   = pre_cnt_q;
    sh_left_d   = sh_left_q;
    post_left_d = post_left_q;
    data_d      = data_q;
    cap_d       = cap_q;
    mask_d      = mask_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    tap_d       = tap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    is_scan     = (op_q == OP_IR) || (op_q == OP_DR);
    new_scan    = (cmd_op == OP_IR) || (cmd_op == OP_DR);
    len_cl      = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_SETUP;
          phase_d     = 1'b0;
          op_d        = cmd_op;
          data_d      = cmd_data;
          cap_d       = '0;
          mask_d      = DATA_W'(1);
          sh_left_d   = (cmd_op == OP_RESET) ? '0 : len_cl;
          post_left_d = (new_scan && (len_cl != '0)) ? 2'd2 : 2'd0;
          // Navigation TMS bits, LSB is sent first
          case (cmd_op)
            OP_RESET: begin pre_pat_d = 7'b0011111; pre_cnt_d = 3'd6; end
            OP_DR:    begin pre_pat_d = 7'b0000001; pre_cnt_d = 3'd3; end
            OP_IR:    begin pre_pat_d = 7'b0000011; pre_cnt_d = 3'd4; end
            default:  begin pre_pat_d = 7'b0000000; pre_cnt_d = 3'd0; end
          endcase
          if (cmd_op != OP_RESET) begin
            if (len_cl == '0) begin
              pre_cnt_d = 3'd0;
            end else if (tap_q == ST_TLR) begin
              pre_pat_d = pre_pat_d << 1;
              pre_cnt_d = pre_cnt_d + 3'd1;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if ((state_q != S_SETUP) && !phase_q) begin
          // End of phase L: TCK rises, target and mirror step, TDO is captured
          tck_d   = 1'b1;
          phase_d = 1'b1;
          tap_d   = tap_next(tap_q, tms_q);
          if ((state_q == S_SHIFT) && is_scan) begin
            if (TDO) cap_d = cap_q | mask_q;
            mask_d = mask_q << 1;
          end
        end else begin
          tck_d   = 1'b0;
          phase_d = 1'b0;
          if (pre_cnt_q != 3'd0) begin
            state_d   = S_PRE;
            tms_d     = pre_pat_q[0];
            tdi_d     = 1'b0;
            pre_pat_d = pre_pat_q >> 1;
            pre_cnt_d = pre_cnt_q - 3'd1;
          end else if (sh_left_q != '0) begin
            state_d   = S_SHIFT;
            tms_d     = is_scan && (sh_left_q == LEN_W'(1));
            tdi_d     = is_scan && data_q[0];
            data_d    = data_q >> 1;
            sh_left_d = sh_left_q - LEN_W'(1);
          end else if (post_left_q != 2'd0) begin
            state_d     = S_POST;
            tms_d       = post_left_q[1];
            tdi_d       = 1'b0;
            post_left_d = post_left_q - 2'd1;
          end else begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
          end
        end
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      op_q        <= OP_RESET;
      pre_pat_q   <= '0;
      pre_cnt_q   <= '0;
      sh_left_q   <= '0;
      post_left_q <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      tap_q       <= ST_TLR;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      op_q        <= op_d;
      pre_pat_q   <= pre_pat_d;
      pre_cnt_q   <= pre_cnt_d;
      sh_left_q   <= sh_left_d;
      post_left_q <= post_left_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      tap_q       <= tap_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
    data_q <= data_d;
    cap_q  <= cap_d;
    mask_q <= mask_d;
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
`ifdef JTAG_DRV_STATE_OBS_EN
  assign tap_state = tap_q;
`endif

endmodule
